axis_frame_gen: RTL and testbench

Test-traffic source for the speed tester transmit path. It builds Ethernet frames byte by byte on an 8-bit AXI-Stream master. The frames carry a programmable header, a 32-bit sequence number and an incrementing payload pattern. The output feeds the transmit FIFO/GMII transmitter stage directly, which adds the preamble, padding, FCS and inter-frame gap, so this block emits no FCS.

---
 rtl/axis_frame_gen.sv | 188 ++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// Test-traffic frame source: programmable Ethernet header, 32-bit sequence number,
// incrementing payload, byte-wide AXI-Stream master. No FCS is produced here.
module axis_frame_gen #(
    parameter int USER_WIDTH = 1,
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1514
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [47:0]           dst_mac,
    input  logic [47:0]           src_mac,
    input  logic [15:0]           ethertype,
    input  logic [10:0]           frame_len,
    input  logic [31:0]           frame_count,
    input  logic [15:0]           gap_cycles,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           frames_sent
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    state_t      state_q, state_d;
    logic [47:0] dst_q, dst_d, src_q, src_d;
    logic [15:0] eth_q, eth_d, gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [10:0] len_q, len_d, idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d, seq_q, seq_d, frames_q, frames_d;
    logic        pend_q, pend_d, tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic        done_q, done_d, busy_q, busy_d;
    logic [7:0]  tdata_q, tdata_d;

    logic [10:0]  nidx, len_in;
    logic [143:0] hdr, hdr_sh;
    logic [7:0]   nbyte;
    logic [31:0]  frames_inc;
    logic         xfer;

    // Byte for the next index: header bytes come MSB-first from one shifted vector.
    always_comb begin
        nidx   = idx_q + 11'd1;
        hdr    = {dst_q, src_q, eth_q, seq_q};
        hdr_sh = hdr << {nidx[4:0], 3'b000};
        nbyte  = (nidx < 11'd18) ? hdr_sh[143:136] : nidx[7:0];
        len_in = (frame_len < MIN_L) ? MIN_L : (frame_len > MAX_L) ? MAX_L : frame_len;
    end

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        src_d      = src_q;
        eth_d      = eth_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        frames_d   = frames_q;
        pend_d     = pend_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        done_d     = 1'b0;
        frames_inc = frames_q + 32'd1;
        xfer       = tvalid_q & m_axis_tready;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEND;
                    dst_d    = dst_mac;
                    src_d    = src_mac;
                    eth_d    = ethertype;
                    len_d    = len_in;
                    cnt_d    = frame_count;
                    gap_d    = gap_cycles;
                    seq_d    = 32'd0;
                    frames_d = 32'd0;
                    pend_d   = 1'b0;
                    idx_d    = 11'd0;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = dst_mac[47:40];
                end
            end
            SEND: begin
                if (stop) pend_d = 1'b1;
                if (xfer) begin
                    if (tlast_q) begin
                        frames_d = frames_inc;
                        seq_d    = seq_q + 32'd1;
                        idx_d    = 11'd0;
                        tlast_d  = 1'b0;
                        if (pend_q || stop || (cnt_q != 32'd0 && frames_inc == cnt_q)) begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                            tdata_d  = 8'd0;
                            done_d   = 1'b1;
                            pend_d   = 1'b0;
                        end else if (gap_q != 16'd0) begin
                            state_d   = GAP;
                            tvalid_d  = 1'b0;
                            tdata_d   = 8'd0;
                            gap_cnt_d = gap_q;
                        end else begin
                            tdata_d = dst_q[47:40];
                        end
                    end else begin
                        idx_d   = nidx;
                        tdata_d = nbyte;
                        tlast_d = (nidx == len_q - 11'd1);
                    end
                end
            end
            GAP: begin
                if (stop || pend_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    pend_d  = 1'b0;
                end else if (gap_cnt_q == 16'd1) begin
                    state_d  = SEND;
                    tvalid_d = 1'b1;
                    tdata_d  = dst_q[47:40];
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dst_q     <= '0;
            src_q     <= '0;
            eth_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            seq_q     <= '0;
            frames_q  <= '0;
            pend_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            eth_q     <= eth_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            frames_q  <= frames_d;
            pend_q    <= pend_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = '0;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frames_sent   = frames_q;
endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: frame contents, clamping, gaps, backpressure,
// stop handling and asynchronous reset.
module tb_axis_frame_gen;
    localparam logic [47:0] DST = 48'hA1B2C3D4E5F6;
    localparam logic [47:0] SRC = 48'h66778899AABB;
    localparam logic [15:0] ETH = 16'h88B5;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] ethertype, gap_cycles;
    logic [10:0] frame_len;
    logic [31:0] frame_count, frames_sent;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, busy, done;
    logic [0:0]  m_axis_tuser;

    int   n_chk = 0, n_err = 0, cyc = 0, done_cnt = 0;
    bit   bp_en = 1'b0;
    logic [7:0] q_data[$];
    logic       q_last[$];
    int         q_cyc[$];
    bit         in_frame = 1'b0, stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    axis_frame_gen #(.USER_WIDTH(1), .MIN_LEN(60), .MAX_LEN(1514)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
        .frame_len(frame_len), .frame_count(frame_count), .gap_cycles(gap_cycles),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .busy(busy), .done(done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] s);
        if (i < 6)       return 8'(DST >> (8 * (5 - i)));
        else if (i < 12) return 8'(SRC >> (8 * (11 - i)));
        else if (i < 14) return 8'(ETH >> (8 * (13 - i)));
        else if (i < 18) return 8'(s >> (8 * (17 - i)));
        else             return 8'(i);
    endfunction

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Transfers are observed at the falling edge; they commit on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            in_frame   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_tvalid", m_axis_tvalid, 1);
                chk("hold_tdata", m_axis_tdata, prev_data);
                chk("hold_tlast", m_axis_tlast, prev_last);
            end
            if (in_frame) chk("no_tvalid_drop", m_axis_tvalid, 1);
            if (m_axis_tvalid && m_axis_tready) begin
                q_data.push_back(m_axis_tdata);
                q_last.push_back(m_axis_tlast);
                q_cyc.push_back(cyc);
                in_frame = !m_axis_tlast;
            end
            if (done) done_cnt++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic start_run(input logic [10:0] len, input logic [31:0] cnt,
                             input logic [15:0] gap, input logic with_stop);
        dst_mac = DST; src_mac = SRC; ethertype = ETH;
        frame_len = len; frame_count = cnt; gap_cycles = gap;
        q_data.delete(); q_last.delete(); q_cyc.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; stop = with_stop;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        chk("start_tvalid", m_axis_tvalid, 1);
        chk("start_byte0", m_axis_tdata, 8'hA1);
        chk("start_busy", busy, 1);
    endtask

    task automatic wait_done(input string tag, input int maxc, input int lat);
        bit seen = 1'b0;
        int dcyc = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; dcyc = cyc; end
        end
        #1;
        chk({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_busy_low"}, busy, 0);
            if (lat > 0 && q_cyc.size() > 0) chk({tag, "_done_latency"}, dcyc - q_cyc[$], lat);
        end
    endtask

    task automatic wait_q(input string tag, input int n, input int maxc);
        bit ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk); #1;
            if (q_data.size() >= n) ok = 1'b1;
        end
        chk({tag, "_reached"}, ok, 1);
    endtask

    task automatic check_frames(input string tag, input int nfr, input int len,
                                input int gap, input bit timing);
        int errs, k;
        chk({tag, "_nbytes"}, q_data.size(), nfr * len);
        if (q_data.size() == nfr * len) begin
            for (int f = 0; f < nfr; f++) begin
                errs = 0;
                for (int i = 0; i < len; i++) begin
                    k = f * len + i;
                    if (q_data[k] !== exp_byte(i, f)) errs++;
                    if (q_last[k] !== (i == len - 1)) errs++;
                    if (timing && i > 0 && q_cyc[k] - q_cyc[k-1] != 1) errs++;
                end
                chk({tag, "_frame_errs"}, errs, 0);
                if (timing && f > 0) chk({tag, "_gap"}, q_cyc[f*len] - q_cyc[f*len-1], gap + 1);
            end
        end
    endtask

    initial begin
        bit found;
        dst_mac = DST; src_mac = SRC; ethertype = ETH;
        frame_len = 11'd64; frame_count = 32'd1; gap_cycles = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frames", frames_sent, 0);
        rst = 1'b0;

        // single frame; a stop in the start cycle must be discarded
        start_run(11'd64, 32'd1, 16'd0, 1'b1);
        wait_done("single", 200, 1);
        chk("single_nbytes", q_data.size(), 64);
        if (q_data.size() == 64) begin
            for (int i = 14; i < 18; i++) chk("single_seq_byte", q_data[i], 8'h00);
            chk("single_b18", q_data[18], 8'h12);
            chk("single_b63", q_data[63], 8'h3F);
            chk("single_tlast63", q_last[63], 1);
            chk("single_span", q_cyc[63] - q_cyc[0], 63);
        end
        check_frames("single", 1, 64, 0, 1);
        chk("single_frames_sent", frames_sent, 1);

        start_run(11'd10, 32'd1, 16'd0, 1'b0);
        wait_done("clamp_lo", 200, 1);
        check_frames("clamp_lo", 1, 60, 0, 1);

        start_run(11'd2000, 32'd1, 16'd0, 1'b0);
        wait_done("clamp_hi", 2000, 1);
        check_frames("clamp_hi", 1, 1514, 0, 1);
        if (q_data.size() == 1514) chk("clamp_hi_last", q_data[1513], 8'hE9);

        // three frames with a 5-cycle gap; inputs change after start and must be ignored
        start_run(11'd60, 32'd3, 16'd5, 1'b0);
        dst_mac = 48'd0; frame_len = 11'd70; gap_cycles = 16'd0; frame_count = 32'd0;
        wait_done("three", 600, 1);
        check_frames("three", 3, 60, 5, 1);
        if (q_data.size() == 180) chk("three_seq2", q_data[120+17], 8'h02);
        chk("three_frames_sent", frames_sent, 3);
        repeat (4) @(negedge clk);
        chk("three_done_once", done_cnt, 1);

        bp_en = 1'b1;
        start_run(11'd64, 32'd2, 16'd0, 1'b0);
        wait_done("bp", 2000, 1);
        bp_en = 1'b0;
        check_frames("bp", 2, 64, 0, 0);
        chk("bp_frames_sent", frames_sent, 2);

        // continuous run, stop in the middle of frame 2
        start_run(11'd60, 32'd0, 16'd0, 1'b0);
        wait_q("stop_mid", 90, 500);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_done("stop_mid", 200, 1);
        check_frames("stop_mid", 2, 60, 0, 1);
        chk("stop_mid_frames_sent", frames_sent, 2);

        // stop while in the inter-frame gap
        start_run(11'd60, 32'd0, 16'd20, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk); #1;
            if (q_data.size() >= 60 && !m_axis_tvalid) found = 1'b1;
        end
        chk("gapstop_in_gap", found, 1);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        chk("gapstop_busy", busy, 0);
        chk("gapstop_done", done, 1);
        chk("gapstop_frames_sent", frames_sent, 1);
        repeat (25) @(negedge clk);
        chk("gapstop_no_more", q_data.size(), 60);

        // asynchronous reset on byte 30, then a clean restart
        start_run(11'd100, 32'd0, 16'd0, 1'b0);
        wait_q("rst_mid", 30, 500);
        @(posedge clk); #1;
        chk("rst_mid_b30", m_axis_tdata, 8'h1E);
        rst = 1'b1;
        #1;
        chk("rst_mid_tvalid", m_axis_tvalid, 0);
        chk("rst_mid_tlast", m_axis_tlast, 0);
        chk("rst_mid_tdata", m_axis_tdata, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_frames", frames_sent, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        start_run(11'd60, 32'd1, 16'd0, 1'b0);
        wait_done("rst_restart", 200, 1);
        check_frames("rst_restart", 1, 60, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
